hdlc_line_monitor: RTL and testbench
====================================

# hdlc_line_monitor

- Synthesizable, parametrised per-channel HDLC serial line monitor; one channel of it is the RTL counterpart of the bench-only flag, abort and idle checks.
- Sits on the Rx or Tx bit line of each HDLC channel.
- Tracks framing state and reports flag, end-of-frame, abort, alignment and length events as registered pulses.
- Keeps a saturating per-channel error count readable by software.

## Interface
- CHANNELS, 1: number of independent serial lines (1..16).
- MAX_BYTES, 128: largest legal frame, in bytes between flags.
- MIN_BYTES, 4: smallest legal frame, in bytes (address + control + FCS16).
- IDLE_MIN, 15: consecutive ones outside a frame that declare idle; legal 7..15.
- CNT_W, 16: error counter width.
- Clk  in  1  clock.
- Rst  in  1  asynchronous active-low reset.
- En  in  1  bit strobe; line samples are taken only when high.
- Line  in  CHANNELS  serial bit per channel.
- ErrClr  in  1  synchronous clear of all error counters.
- FlagPulse  out  CHANNELS  flag 0x7E completed.
- FrameEnd  out  CHANNELS  closing flag of a non-empty frame.
- AbortPulse  out  CHANNELS  abort seen inside a frame.
- AlignErr  out  CHANNELS  closed frame not a whole number of bytes.
- LenErr  out  CHANNELS  closed frame shorter than MIN_BYTES or longer than MAX_BYTES.
- Idle  out  CHANNELS  level; channel is in the IDLE state.
- ErrCnt  out  CHANNELS x CNT_W  per-channel error count.

## Operation
Channel state
- All channels are identical and independent.
- Per channel: 8-bit shift register sreg, saturating 4-bit ones-run counter ones, destuffed bit counter cnt (clog2(MAX_BYTES*8+8)+1 bits, saturating), FSM.
- On each enabled sample b: sreg <= {sreg[6:0], b}; ones <= b ? sat(ones+1) : 0.
- flag = ({sreg[6:0], b} == 8'h7E).

FSM
- HUNT: on flag go to OPEN; on ones+1 == IDLE_MIN go to IDLE.
- IDLE: on flag go to OPEN; otherwise stay. Idle = 1 only in this state.
- OPEN: on any sample go to FRAME with cnt = 1 if that sample is counted.
- FRAME:
  - Every sample is counted except a stuffed zero (b == 0 with prior ones == 5).
  - On flag:
    - cnt <= 7: inter-frame fill; go to OPEN, no FrameEnd.
    - Otherwise: data_bits = cnt - 7. Pulse FrameEnd. Pulse AlignErr if data_bits % 8 != 0. Pulse LenErr if data_bits < MIN_BYTES*8 or data_bits > MAX_BYTES*8. Go to OPEN.
  - On ones+1 == 7:
    - cnt == 7 means only ones since the flag; go to HUNT silently.
    - Otherwise pulse AbortPulse and go to HUNT.
- FlagPulse fires on every detected flag, in any state.

Error counter
- Increments by exactly 1 on any cycle with AbortPulse | AlignErr | LenErr.
- Saturates at all-ones.
- ErrClr has priority over increment in the same cycle.

## Timing
- All outputs are registered. Event pulses are high for exactly one Clk cycle, the cycle after the enabled sample that completes the event.
- En low: no state, counter or sreg change; pulses deassert.
- Reset values:
  - Every output is 0, including Idle and ErrCnt.
  - FSM = HUNT; sreg = 0, ones = 0, cnt = 0.
- Reset mid-frame discards the frame; no pulse is generated.
- Simultaneous events:
  - FrameEnd, AlignErr and LenErr may fire in the same cycle.
  - Flag and abort cannot coincide, since the flag ends in 0.
- cnt saturation guarantees LenErr for frames over MAX_BYTES with no wrap-around.

## Configuration
- HDLC_MON_ERRCNT_EN defined: the per-channel error counters and ErrClr are compiled in.
- HDLC_MON_ERRCNT_EN undefined:
  - No counter flops.
  - ErrCnt is tied to 0 and ErrClr is ignored.
  - All event pulses behave identically.

## Structure
- hdlc_mon_pkg holds:
  - FSM enum (HUNT, IDLE, OPEN, FRAME).
  - FLAG_PATTERN = 8'h7E, ABORT_ONES = 7, STUFF_ONES = 5.
  - FLAG_TAIL_BITS = 7.
- Sub-module hdlc_mon_chan implements one channel: sreg, ones, cnt, FSM, counter.
- hdlc_line_monitor instantiates hdlc_mon_chan CHANNELS times in a generate loop.

## Test plan
- Reset: assert Rst low mid-frame, release -> all outputs 0, Idle 0. Drive 15 ones with En high -> Idle = 1 on the cycle after the 15th sample.
- Good frame on ch0: 7E, bytes 00 11 22 33, 7E -> FlagPulse twice, one FrameEnd, no AlignErr/LenErr, ErrCnt 0.
- Stuffing: frame FF FF FF FF sent with stuffed zeros -> FrameEnd with no AlignErr (stuffed zeros excluded). Back-to-back 7E 7E -> no FrameEnd.
- Abort: 7E, 12 data bits, then 7 ones -> AbortPulse one cycle, FSM HUNT, ErrCnt = 1. Flag followed directly by 7 ones -> no AbortPulse.
- Length/alignment: 33 data bits -> AlignErr. 16 data bits -> LenErr. 129 bytes -> LenErr. 3 data bits -> AlignErr and LenErr in the same cycle with ErrCnt +1 only.
- CHANNELS=4, CNT_W=2: errors on ch2 only leave other channels at 0. Four errors -> ErrCnt[2] = 3 (saturated). ErrClr with a simultaneous error -> 0.
- With HDLC_MON_ERRCNT_EN undefined: ErrCnt stays 0 through all of the above.

Source files
------------

// File: rtl/hdlc_mon_pkg.sv
// Shared types and constants for the HDLC line monitor.
package hdlc_mon_pkg;

  // Per-channel framing states.
  typedef enum logic [1:0] {
    HUNT,
    IDLE,
    OPEN,
    FRAME
  } mon_state_e;

  localparam logic [7:0] FLAG_PATTERN   = 8'h7E;
  localparam int         ABORT_ONES     = 7;
  localparam int         STUFF_ONES     = 5;
  // Bits of the closing flag already counted when its final zero arrives.
  localparam int         FLAG_TAIL_BITS = 7;

  // Next value of the saturating 4-bit ones-run counter for sample b.
  function automatic logic [3:0] ones_next(input logic [3:0] ones, input logic b);
    if (!b) begin
      return 4'd0;
    end
    return (ones == 4'hF) ? ones : ones + 4'd1;
  endfunction

endpackage

// File: rtl/hdlc_mon_chan.sv
// One HDLC line monitor channel: flag/abort/idle detection, destuffed
// bit counting, frame length/alignment checks and an optional saturating
// error counter (compiled in when HDLC_MON_ERRCNT_EN is defined).
module hdlc_mon_chan
  import hdlc_mon_pkg::*;
#(
  parameter int MAX_BYTES = 128,
  parameter int MIN_BYTES = 4,
  parameter int IDLE_MIN  = 15,
  parameter int CNT_W     = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_en,
  input  logic             i_line,
  input  logic             i_err_clr,
  output logic             o_flag_pulse,
  output logic             o_frame_end,
  output logic             o_abort_pulse,
  output logic             o_align_err,
  output logic             o_len_err,
  output logic             o_idle,
  output logic [CNT_W-1:0] o_err_cnt
);

  localparam int CNT_BITS = $clog2(MAX_BYTES * 8 + 8) + 1;
  localparam logic [CNT_BITS-1:0] CNT_SAT  = '1;
  localparam logic [CNT_BITS-1:0] TAIL     = CNT_BITS'(FLAG_TAIL_BITS);
  localparam logic [CNT_BITS-1:0] MIN_BITS = CNT_BITS'(MIN_BYTES * 8);
  localparam logic [CNT_BITS-1:0] MAX_BITS = CNT_BITS'(MAX_BYTES * 8);

  mon_state_e          r_state, w_state_nxt;
  logic [7:0]          r_sreg;
  logic [3:0]          r_ones;
  logic [CNT_BITS-1:0] r_cnt, w_cnt_nxt;
  logic                r_flag_pulse, r_frame_end, r_abort_pulse, r_align_err, r_len_err, r_idle;

  logic [7:0]          w_sample;
  logic                w_flag;
  logic [3:0]          w_ones_nxt;
  logic                w_stuffed;
  logic [CNT_BITS-1:0] w_cnt_inc;
  logic [CNT_BITS-1:0] w_data_bits;
  logic                w_frame_end, w_abort, w_align, w_len;
  logic                w_unused;

  assign w_sample    = {r_sreg[6:0], i_line};
  assign w_flag      = (w_sample == FLAG_PATTERN);
  assign w_ones_nxt  = ones_next(r_ones, i_line);
  assign w_stuffed   = !i_line && (r_ones == 4'(STUFF_ONES));
  assign w_cnt_inc   = (r_cnt == CNT_SAT) ? r_cnt : r_cnt + CNT_BITS'(1);
  assign w_data_bits = r_cnt - TAIL;

  // Next-state, bit count and event decode for the current sample.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_frame_end = 1'b0;
    w_abort     = 1'b0;
    w_align     = 1'b0;
    w_len       = 1'b0;
    if (i_en) begin
      case (r_state)
        HUNT: begin
          if (w_flag) begin
            w_state_nxt = OPEN;
          end else if (w_ones_nxt == 4'(IDLE_MIN)) begin
            w_state_nxt = IDLE;
          end
        end
        IDLE: begin
          if (w_flag) begin
            w_state_nxt = OPEN;
          end
        end
        OPEN: begin
          w_state_nxt = FRAME;
          w_cnt_nxt   = w_stuffed ? '0 : CNT_BITS'(1);
        end
        FRAME: begin
          if (w_flag) begin
            w_state_nxt = OPEN;
            // Seven or fewer bits since the last flag is shared-zero fill.
            if (r_cnt > TAIL) begin
              w_frame_end = 1'b1;
              w_align     = (w_data_bits[2:0] != 3'd0);
              w_len       = (w_data_bits < MIN_BITS) || (w_data_bits > MAX_BITS);
            end
          end else if (w_ones_nxt == 4'(ABORT_ONES)) begin
            w_state_nxt = HUNT;
            // Only ones since the flag means the line went idle, not an abort.
            w_abort     = (w_cnt_inc != TAIL);
          end else if (!w_stuffed) begin
            w_cnt_nxt = w_cnt_inc;
          end
        end
        default: w_state_nxt = HUNT;
      endcase
    end
  end

  // Line history, FSM state and registered event pulses.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= HUNT;
      r_sreg        <= '0;
      r_ones        <= '0;
      r_cnt         <= '0;
      r_flag_pulse  <= 1'b0;
      r_frame_end   <= 1'b0;
      r_abort_pulse <= 1'b0;
      r_align_err   <= 1'b0;
      r_len_err     <= 1'b0;
      r_idle        <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge values of the others.
      if (i_en) begin
        r_sreg <= w_sample;
        r_ones <= w_ones_nxt;
      end
      r_state       <= w_state_nxt;
      r_cnt         <= w_cnt_nxt;
      r_flag_pulse  <= i_en && w_flag;
      r_frame_end   <= w_frame_end;
      r_abort_pulse <= w_abort;
      r_align_err   <= w_align;
      r_len_err     <= w_len;
      r_idle        <= (w_state_nxt == IDLE);
    end
  end

  assign o_flag_pulse  = r_flag_pulse;
  assign o_frame_end   = r_frame_end;
  assign o_abort_pulse = r_abort_pulse;
  assign o_align_err   = r_align_err;
  assign o_len_err     = r_len_err;
  assign o_idle        = r_idle;

`ifdef HDLC_MON_ERRCNT_EN
  logic [CNT_W-1:0] r_err_cnt;

  // Saturating error count; a clear wins over a same-cycle increment.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_err_cnt <= '0;
    end else if (i_err_clr) begin
      r_err_cnt <= '0;
    end else if ((r_abort_pulse || r_align_err || r_len_err) && (r_err_cnt != '1)) begin
      r_err_cnt <= r_err_cnt + CNT_W'(1);
    end
  end

  assign o_err_cnt = r_err_cnt;
  assign w_unused  = r_sreg[7];
`else
  assign o_err_cnt = '0;
  assign w_unused  = ^{i_err_clr, r_sreg[7]};
`endif

endmodule

// File: rtl/hdlc_line_monitor.sv
// Multi-channel HDLC serial line monitor: one independent hdlc_mon_chan
// per line. Error counters exist only when HDLC_MON_ERRCNT_EN is defined;
// otherwise o_err_cnt reads 0 and i_err_clr is ignored.
module hdlc_line_monitor
  import hdlc_mon_pkg::*;
#(
  parameter int CHANNELS  = 1,
  parameter int MAX_BYTES = 128,
  parameter int MIN_BYTES = 4,
  parameter int IDLE_MIN  = 15,
  parameter int CNT_W     = 16
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_en,
  input  logic [CHANNELS-1:0]       i_line,
  input  logic                      i_err_clr,
  output logic [CHANNELS-1:0]       o_flag_pulse,
  output logic [CHANNELS-1:0]       o_frame_end,
  output logic [CHANNELS-1:0]       o_abort_pulse,
  output logic [CHANNELS-1:0]       o_align_err,
  output logic [CHANNELS-1:0]       o_len_err,
  output logic [CHANNELS-1:0]       o_idle,
  output logic [CHANNELS*CNT_W-1:0] o_err_cnt
);

  // One monitor per serial line; channel g owns bits [g*CNT_W +: CNT_W] of the count bus.
  for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
    hdlc_mon_chan #(
      .MAX_BYTES (MAX_BYTES),
      .MIN_BYTES (MIN_BYTES),
      .IDLE_MIN  (IDLE_MIN),
      .CNT_W     (CNT_W)
    ) u_chan (
      .i_clk         (i_clk),
      .i_rst_n       (i_rst_n),
      .i_en          (i_en),
      .i_line        (i_line[g]),
      .i_err_clr     (i_err_clr),
      .o_flag_pulse  (o_flag_pulse[g]),
      .o_frame_end   (o_frame_end[g]),
      .o_abort_pulse (o_abort_pulse[g]),
      .o_align_err   (o_align_err[g]),
      .o_len_err     (o_len_err[g]),
      .o_idle        (o_idle[g]),
      .o_err_cnt     (o_err_cnt[g*CNT_W +: CNT_W])
    );
  end

endmodule

// File: tb/tb_hdlc_line_monitor.sv
// Scoreboard bench for hdlc_line_monitor (4 channels, 2-bit error counters).
// Expected counter values depend on HDLC_MON_ERRCNT_EN.
module tb_hdlc_line_monitor;

  localparam int CH = 4;
  localparam int CW = 2;

  localparam logic [4:0] K_FLAG = 5'b10000;
  localparam logic [4:0] K_FE   = 5'b01000;
  localparam logic [4:0] K_AB   = 5'b00100;
  localparam logic [4:0] K_AL   = 5'b00010;
  localparam logic [4:0] K_LE   = 5'b00001;

  logic             clk = 1'b0;
  logic             rst_n, en, err_clr;
  logic [CH-1:0]    line;
  logic [CH-1:0]    o_flag_pulse, o_frame_end, o_abort_pulse, o_align_err, o_len_err, o_idle;
  logic [CH*CW-1:0] o_err_cnt;

  always #5 clk = ~clk;

  hdlc_line_monitor #(
    .CHANNELS  (CH),
    .MAX_BYTES (128),
    .MIN_BYTES (4),
    .IDLE_MIN  (15),
    .CNT_W     (CW)
  ) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_en          (en),
    .i_line        (line),
    .i_err_clr     (err_clr),
    .o_flag_pulse  (o_flag_pulse),
    .o_frame_end   (o_frame_end),
    .o_abort_pulse (o_abort_pulse),
    .o_align_err   (o_align_err),
    .o_len_err     (o_len_err),
    .o_idle        (o_idle),
    .o_err_cnt     (o_err_cnt)
  );

  typedef struct {
    int         ch;
    logic [4:0] kind;
    int         cyc;
  } ev_t;

  ev_t exp_q[$];
  int  cyc = 0;
  int  n_checks = 0;
  int  n_pass = 0;
  int  tx_ones = 0;
  bit  gap = 1'b0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end else begin
      n_pass++;
    end
  endtask

  function automatic logic [63:0] ev_pack(input int ch, input logic [4:0] kind, input int c);
    return {16'(ch), 11'b0, kind, 32'(c)};
  endfunction

  function automatic logic [CW-1:0] exp_err(input int n);
`ifdef HDLC_MON_ERRCNT_EN
    return CW'(n);
`else
    return (n == n) ? '0 : '0;
`endif
  endfunction

  // Monitor: every pulse seen on a channel must match the oldest expectation.
  always @(negedge clk) begin : monitor
    logic [4:0] k;
    ev_t        e;
    if (rst_n) begin
      for (int c = 0; c < CH; c++) begin
        k = {o_flag_pulse[c], o_frame_end[c], o_abort_pulse[c], o_align_err[c], o_len_err[c]};
        if (k != 5'b0) begin
          if (exp_q.size() == 0) begin
            check("unexpected_event", ev_pack(c, k, cyc), 64'd0);
          end else begin
            e = exp_q.pop_front();
            check("event", ev_pack(c, k, cyc), ev_pack(e.ch, e.kind, e.cyc));
          end
        end
      end
    end
  end

  // Event expected from the next sample, visible after the next edge.
  task automatic push_ev(input int ch, input logic [4:0] kind);
    exp_q.push_back('{ch: ch, kind: kind, cyc: cyc + 1});
  endtask

  // One enabled sample on channel ch; other lines idle at 1.
  task automatic drive(input int ch, input logic b, input logic clr);
    logic [CH-1:0] v;
    v       = '1;
    v[ch]   = b;
    line    = v;
    en      = 1'b1;
    err_clr = clr;
    @(posedge clk);
    #1;
    en      = 1'b0;
    err_clr = 1'b0;
    if (gap) begin
      line = ~v;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic quiet(input logic clr);
    en      = 1'b0;
    err_clr = clr;
    @(posedge clk);
    #1;
    err_clr = 1'b0;
  endtask

  task automatic send_flag(input int ch, input logic [4:0] extra);
    drive(ch, 1'b0, 1'b0);
    repeat (6) drive(ch, 1'b1, 1'b0);
    push_ev(ch, K_FLAG | extra);
    drive(ch, 1'b0, 1'b0);
    tx_ones = 0;
  endtask

  task automatic send_data_bit(input int ch, input logic b);
    drive(ch, b, 1'b0);
    if (b) begin
      tx_ones++;
      if (tx_ones == 5) begin
        drive(ch, 1'b0, 1'b0);
        tx_ones = 0;
      end
    end else begin
      tx_ones = 0;
    end
  endtask

  task automatic send_byte(input int ch, input logic [7:0] d);
    for (int i = 0; i < 8; i++) send_data_bit(ch, d[i]);
  endtask

  task automatic send_zeros(input int ch, input int n);
    for (int i = 0; i < n; i++) drive(ch, 1'b0, 1'b0);
    tx_ones = 0;
  endtask

  // Seven ones; optionally expect an abort and clear the counter in the pulse cycle.
  task automatic send_seven_ones(input int ch, input bit exp_abort, input bit clr_in_pulse);
    repeat (6) drive(ch, 1'b1, 1'b0);
    if (exp_abort) push_ev(ch, K_AB);
    drive(ch, 1'b1, 1'b0);
    if (clr_in_pulse) drive(ch, 1'b1, 1'b1);
    tx_ones = 0;
  endtask

  function automatic logic [63:0] all_outputs();
    return 64'({o_flag_pulse, o_frame_end, o_abort_pulse, o_align_err, o_len_err, o_idle, o_err_cnt});
  endfunction

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : stimulus
    rst_n   = 1'b0;
    en      = 1'b0;
    err_clr = 1'b0;
    line    = '1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", all_outputs(), 64'd0);
    rst_n = 1'b1;

    // Reset in the middle of a frame discards it.
    send_flag(0, 5'b0);
    send_zeros(0, 10);
    #1 rst_n = 1'b0;
    #2 check("midframe_reset_outputs", all_outputs(), 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    check("after_release_outputs", all_outputs(), 64'd0);

    // Idle after 15 consecutive ones.
    repeat (14) drive(0, 1'b1, 1'b0);
    check("idle_after_14", 64'(o_idle[0]), 64'd0);
    drive(0, 1'b1, 1'b0);
    check("idle_after_15", 64'(o_idle[0]), 64'd1);

    // Good 4-byte frame with disabled cycles between samples.
    gap = 1'b1;
    send_flag(0, 5'b0);
    check("idle_cleared_by_flag", 64'(o_idle[0]), 64'd0);
    send_byte(0, 8'h00);
    send_byte(0, 8'h11);
    send_byte(0, 8'h22);
    send_byte(0, 8'h33);
    send_flag(0, K_FE);
    gap = 1'b0;
    quiet(1'b0);
    check("errcnt_good_frame", 64'(o_err_cnt[0 +: CW]), 64'(exp_err(0)));

    // All-ones payload with stuffed zeros, then back-to-back flags.
    send_flag(0, 5'b0);
    for (int i = 0; i < 4; i++) send_byte(0, 8'hFF);
    send_flag(0, K_FE);
    send_flag(0, 5'b0);
    quiet(1'b0);
    check("errcnt_stuffed_frame", 64'(o_err_cnt[0 +: CW]), 64'(exp_err(0)));

    // Abort after 12 data bits.
    send_flag(0, 5'b0);
    send_zeros(0, 12);
    send_seven_ones(0, 1'b1, 1'b0);
    check("idle_after_abort", 64'(o_idle[0]), 64'd0);
    quiet(1'b0);
    check("errcnt_abort", 64'(o_err_cnt[0 +: CW]), 64'(exp_err(1)));
    repeat (8) drive(0, 1'b1, 1'b0);
    check("idle_after_abort_hunt", 64'(o_idle[0]), 64'd1);

    // Flag directly followed by seven ones is not an abort.
    send_flag(0, 5'b0);
    send_seven_ones(0, 1'b0, 1'b0);
    repeat (8) drive(0, 1'b1, 1'b0);
    check("idle_after_silent_hunt", 64'(o_idle[0]), 64'd1);
    check("errcnt_silent", 64'(o_err_cnt[0 +: CW]), 64'(exp_err(1)));
    quiet(1'b1);
    check("errcnt_cleared", 64'(o_err_cnt[0 +: CW]), 64'd0);

    // Length and alignment.
    send_flag(0, 5'b0);
    send_zeros(0, 33);
    send_flag(0, K_FE | K_AL);
    quiet(1'b0);
    check("errcnt_align33", 64'(o_err_cnt[0 +: CW]), 64'(exp_err(1)));
    send_zeros(0, 16);
    send_flag(0, K_FE | K_LE);
    quiet(1'b0);
    check("errcnt_len16", 64'(o_err_cnt[0 +: CW]), 64'(exp_err(2)));
    quiet(1'b1);
    send_zeros(0, 3);
    send_flag(0, K_FE | K_AL | K_LE);
    quiet(1'b0);
    check("errcnt_both3", 64'(o_err_cnt[0 +: CW]), 64'(exp_err(1)));
    for (int i = 0; i < 128; i++) send_byte(0, 8'(i));
    send_flag(0, K_FE);
    quiet(1'b0);
    check("errcnt_max128", 64'(o_err_cnt[0 +: CW]), 64'(exp_err(1)));
    for (int i = 0; i < 129; i++) send_byte(0, 8'(i));
    send_flag(0, K_FE | K_LE);
    quiet(1'b0);
    check("errcnt_over129", 64'(o_err_cnt[0 +: CW]), 64'(exp_err(2)));

    // Channel isolation and saturation on ch2.
    quiet(1'b1);
    check("errcnt_all_cleared", 64'(o_err_cnt), 64'd0);
    for (int k = 1; k <= 4; k++) begin
      send_flag(2, 5'b0);
      send_zeros(2, 12);
      send_seven_ones(2, 1'b1, 1'b0);
      quiet(1'b0);
      check("errcnt_ch2", 64'(o_err_cnt[2*CW +: CW]), 64'(exp_err(k > 3 ? 3 : k)));
    end
    check("errcnt_others", 64'({o_err_cnt[3*CW +: CW], o_err_cnt[CW +: CW], o_err_cnt[0 +: CW]}), 64'd0);
    quiet(1'b1);
    check("errcnt_ch2_cleared", 64'(o_err_cnt[2*CW +: CW]), 64'd0);

    // Clear in the same cycle as an error pulse wins.
    send_flag(2, 5'b0);
    send_zeros(2, 12);
    send_seven_ones(2, 1'b1, 1'b1);
    quiet(1'b0);
    check("errcnt_clr_priority", 64'(o_err_cnt[2*CW +: CW]), 64'd0);

    repeat (3) quiet(1'b0);
    check("expect_queue_empty", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
